aes128_decryptor: RTL and testbench

Iterative AES-128 decryption core with a feedback round datapath: one inverse round per clock, with round keys derived on the fly. It is the receive-side counterpart of the team's AES-128 encryption co-processor, and accepts that block's ciphertext together with the same cipher key. Before the inverse rounds, it expands the cipher key forward to the last round key. It then walks the inverse key schedule backward, one key per round.

---
 rtl/aes_pkg.sv | 110 +++++++++++
 rtl/aes_inv_round_function.sv | 35 +++
 rtl/aes128_decryptor.sv | 134 +++++++++++++
 tb/tb_aes128_decryptor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 arithmetic: GF(2^8) helpers, S-boxes, rcon, key-schedule steps
// and the decryptor FSM state type.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_LOAD,
    ST_ROUND,
    ST_DONE
  } dec_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // K(i-1) -> K(i); rc is rcon[i].
  function automatic logic [127:0] key_fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // K(i) -> K(i-1); rc is rcon[i]. The leading word needs the recovered last word.
  function automatic logic [127:0] key_inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round_function.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round is set.
module aes_inv_round_function
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] next_state
);

  logic [7:0] sub_b [16];

  // Byte i = 4*col + row sits at bits [127-8i -: 8]; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub_b[4*c+r] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8])
                          ^ round_key[127-8*(4*c+r) -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sub_b[4*c];
    assign a1 = sub_b[4*c+1];
    assign a2 = sub_b[4*c+2];
    assign a3 = sub_b[4*c+3];

    assign next_state[127-32*c -: 32] = last_round ? {a0, a1, a2, a3} : {
      mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
      mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
      mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
      mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)
    };
  end

endmodule

// File: rtl/aes128_decryptor.sv
// Iterative AES-128 decryptor: forward key expansion, then one inverse round per clock.
// Optional last-key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes128_decryptor
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] ciphertext_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] plaintext_o
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  dec_fsm_e         fsm_q;
  logic [3:0]       round_q;
  logic [WIDTH-1:0] ct_q;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] key_fwd;
  logic [WIDTH-1:0] key_inv;
  logic [WIDTH-1:0] round_out;
  logic             accept;

  // busy_o is low only in IDLE and DONE, so a start in the valid_o cycle is taken.
  assign accept  = start && !busy_o;
  assign key_fwd = key_fwd_step(key_q, rcon(round_q));
  assign key_inv = key_inv_step(key_q, rcon(round_q));

`ifdef AES_DEC_KEY_CACHE_EN
  logic [WIDTH-1:0] last_k0_q;
  logic [WIDTH-1:0] cached_k10_q;
  logic             cache_valid_q;
  logic             cache_hit;

  assign cache_hit = cache_valid_q && (key_i == last_k0_q);
`endif

  aes_inv_round_function u_inv_round (
    .state      (state_q),
    .round_key  (key_q),
    .last_round (round_q == 4'd0),
    .next_state (round_out)
  );

  // NOTE: state and outputs use non-blocking assignments so every branch reads
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q         <= ST_IDLE;
      round_q       <= 4'd0;
      ct_q          <= '0;
      key_q         <= '0;
      state_q       <= '0;
      busy_o        <= 1'b0;
      valid_o       <= 1'b0;
      plaintext_o   <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      last_k0_q     <= '0;
      cached_k10_q  <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          fsm_q <= ST_IDLE;
          if (accept) begin
            ct_q   <= ciphertext_i;
            busy_o <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              key_q   <= cached_k10_q;
              round_q <= LAST_ROUND;
              fsm_q   <= ST_LOAD;
            end else begin
              key_q         <= key_i;
              round_q       <= 4'd1;
              fsm_q         <= ST_EXPAND;
              last_k0_q     <= key_i;
              cache_valid_q <= 1'b0;
            end
`else
            key_q   <= key_i;
            round_q <= 4'd1;
            fsm_q   <= ST_EXPAND;
`endif
          end
        end

        ST_EXPAND: begin
          key_q <= key_fwd;
          if (round_q == LAST_ROUND) begin
            fsm_q <= ST_LOAD;
`ifdef AES_DEC_KEY_CACHE_EN
            cached_k10_q  <= key_fwd;
            cache_valid_q <= 1'b1;
`endif
          end else begin
            round_q <= round_q + 4'd1;
          end
        end

        ST_LOAD: begin
          state_q <= ct_q ^ key_q;
          key_q   <= key_inv;
          round_q <= round_q - 4'd1;
          fsm_q   <= ST_ROUND;
        end

        ST_ROUND: begin
          state_q <= round_out;
          if (round_q == 4'd0) begin
            plaintext_o <= round_out;
            valid_o     <= 1'b1;
            busy_o      <= 1'b0;
            fsm_q       <= ST_DONE;
          end else begin
            key_q   <= key_inv;
            round_q <= round_q - 4'd1;
          end
        end

        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decryptor.sv
// Self-checking bench for aes128_decryptor: AES encryption reference model,
// cycle-level output timeline model, FIPS-197 vectors and random loopback.
module tb_aes128_decryptor;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT_LAT = CACHE ? 12 : 22;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext_i = '0;
  logic [127:0] key_i = '0;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] plaintext_o;

  always #5 clk_i = ~clk_i;

  aes128_decryptor #(.WIDTH(128)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start        (start),
    .ciphertext_i (ciphertext_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .plaintext_o  (plaintext_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES-128 encryption reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the generator-3 walk over GF(2^8)*: p steps by *3, q by /3 = p^-1.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    sbox_t[0] = 8'h63;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
  endtask

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- Output timeline model ----------------
  // m_cnt counts down to the result cycle: busy while >1, valid at exactly 1.
  int           m_cnt = 0;
  logic [127:0] m_pt = '0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_k0 = '0;
  bit           m_cv = 1'b0;
  logic [127:0] drv_pt = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cnt = 0;
      m_pt  = '0;
      m_cv  = 1'b0;
      m_k0  = '0;
    end else if (start && m_cnt <= 1) begin
      m_cnt  = (CACHE && m_cv && key_i == m_k0) ? 12 : 22;
      m_cv   = 1'b1;
      m_k0   = key_i;
      m_pend = drv_pt;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1) m_pt = m_pend;
    end
  end

  always @(negedge clk_i) begin
    check("busy_o", {127'b0, busy_o}, {127'b0, m_cnt > 1});
    check("valid_o", {127'b0, valid_o}, {127'b0, m_cnt == 1});
    check("plaintext_o", plaintext_o, m_pt);
  end

  // ---------------- Directed driver ----------------
  task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    key_i        = k;
    ciphertext_i = ct;
    drv_pt       = pt;
    start        = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle lat0; returns at the negedge of the valid_o cycle.
  task automatic wait_valid(input string name, input int lat0, input int lat_exp,
                            input logic [127:0] pt_exp);
    int lat;
    lat = lat0;
    while (!valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(lat_exp));
    check({name, " result"}, plaintext_o, pt_exp);
  endtask

  initial begin
    logic [127:0] k, p, prev_k;
    logic [7:0]   idx;
    int           vcount;

    build_sbox();
    idx = 8'h00;
    check("sbox[00]", {120'b0, sbox_t[idx]}, 128'h63);
    idx = 8'h53;
    check("sbox[53]", {120'b0, sbox_t[idx]}, 128'hed);
    check("model C.1", enc(C1_KEY, C1_PT), C1_CT);
    check("model App.B", enc(B_KEY, B_PT), B_CT);

    repeat (2) @(negedge clk_i);
    check("reset busy", {127'b0, busy_o}, 128'h0);
    check("reset valid", {127'b0, valid_o}, 128'h0);
    check("reset plaintext", plaintext_o, 128'h0);
    #2 rst_i = 1'b0;
    @(negedge clk_i);

    // C.1 with an ignored start in cycle 10, then back-to-back C.1 and App.B.
    issue(C1_KEY, C1_CT, C1_PT);
    repeat (9) @(negedge clk_i);
    key_i        = B_KEY;
    ciphertext_i = B_CT;
    drv_pt       = B_PT;
    start        = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    wait_valid("C.1 first", 11, 22, C1_PT);
    issue(C1_KEY, C1_CT, C1_PT);
    wait_valid("C.1 repeat", 1, HIT_LAT, C1_PT);
    issue(B_KEY, B_CT, B_PT);
    wait_valid("App.B", 1, 22, B_PT);

    // Reset asserted in cycle 15 of an operation.
    issue(C1_KEY, C1_CT, C1_PT);
    repeat (14) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midreset busy", {127'b0, busy_o}, 128'h0);
    check("midreset valid", {127'b0, valid_o}, 128'h0);
    check("midreset plaintext", plaintext_o, 128'h0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    vcount = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("aborted valid count", 128'(vcount), 128'h0);
    issue(C1_KEY, C1_CT, C1_PT);
    wait_valid("C.1 after reset", 1, 22, C1_PT);

    // Random loopback against the encryption model; every 4th op reuses the key.
    prev_k = C1_KEY;
    for (int i = 0; i < 1000; i++) begin
      k = (i % 4 == 3) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      issue(k, enc(k, p), p);
      wait_valid("loopback", 1, (i % 4 == 3) ? HIT_LAT : 22, p);
      prev_k = k;
    end

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
